dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Round-robin arbiter and sequencer that shares one single-port, synchronous-read data memory among `NUM_C` cores. It sits between the per-core load/store ports (LDDAC/STDAC/LDAC/STAC traffic) and the shared data RAM. Each access is serialised into a fixed four-state sequence, and the read data is returned to the winning core with a one-cycle acknowledge.

## Interface

**Parameters**

- `NUM_C`, default 4: number of cores (≥1).
- `AW`, default 16: address width.
- `DW`, default 16: data width.

**Ports**

- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `core_req`  in  NUM_C: per-core access request; level, held until ack.
- `core_we`  in  NUM_C: per-core write enable (1 = store, 0 = load); valid while req=1.
- `core_addr`  in  NUM_C*AW: flattened; core i at `[i*AW +: AW]`.
- `core_wdata`  in  NUM_C*DW: flattened; core i at `[i*DW +: DW]`.
- `core_ack`  out  NUM_C: one-hot, one-cycle completion pulse.
- `core_rdata`  out  NUM_C*DW: per-core registered read data; holds until that core's next load completes.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  AW: memory address.
- `mem_wdata`  out  DW: memory write data.
- `mem_rdata`  in  DW: memory read data; valid the cycle after the `mem_en` edge (registered RAM).
- `busy`  out  1: high in any state other than IDLE.
- `grant_id`  out  clog2(NUM_C) (min 1): index of the current or last grantee.

## Operation

**State machine**

- IDLE:
  - If `core_req != 0`, select a winner and go to ISSUE.
  - Latch winner index into `grant_id`.
  - Latch winner's addr, wdata and we into internal registers.
- ISSUE:
  - `mem_en = 1`, `mem_we = latched we`; `mem_addr`/`mem_wdata` come from the latched registers.
  - Go to WAIT.
- WAIT:
  - `mem_en = 0`; `mem_rdata` is valid this cycle.
  - If latched we=0, capture `mem_rdata` into `core_rdata[grant_id]` at the WAIT→ACK edge.
  - Go to ACK.
- ACK:
  - `core_ack[grant_id] = 1`; all other ack bits are 0.
  - Go to IDLE unconditionally.

**Arbitration**

- Round-robin. Search order starts at `(last_grant + 1) mod NUM_C` and ascends with wrap.
- `last_grant` updates when a winner is selected in IDLE.
- `last_grant` resets to `NUM_C-1`, so core 0 has first priority after reset.
- Requests are sampled only in IDLE. Requests raised or dropped in ISSUE/WAIT/ACK do not affect the current access.

**Requester rules**

- A requester holds req, we, addr and wdata stable until it samples `core_ack=1`.
- It deasserts req on that same edge, so req is already low in the following IDLE cycle.
- A req still high in IDLE is treated as a new access.

**Data and outputs**

- Stores leave `core_rdata` unchanged.
- Addresses and data pass through unmodified; there is no width conversion.
- `mem_addr`/`mem_wdata`/`mem_we` hold the latched values outside ISSUE. Only `mem_en` qualifies them.

## Timing

**Latency**

- Latency for a request seen in IDLE cycle t:
  - ISSUE at t+1.
  - WAIT at t+2.
  - ACK at t+3.
  - IDLE at t+4.
- Peak throughput is one access per 4 cycles. Worst-case wait for any core is NUM_C accesses.

**Reset (async, `rst_n=0`)**

- state = IDLE.
- `mem_en`, `mem_we`, `core_ack` = 0.
- `mem_addr`, `mem_wdata`, all `core_rdata` = 0.
- `busy` = 0, `grant_id` = 0, `last_grant` = NUM_C-1.

**Reset mid-access**

- Outputs drop immediately, without waiting for a clock edge.
- The in-flight access is abandoned and no ack is issued. A write aborted before the ISSUE edge is not performed.

**Other boundary cases**

- All cores requesting simultaneously: strict rotation. No core is served twice before every other requester has been served once.
- With NUM_C=1: the arbiter degenerates to a fixed 4-cycle sequencer with `grant_id`=0.

## Test plan

- **Single load:** mem[0x0010]=0xBEEF; core 0 load addr 0x0010 at cycle 0.
  - Required: `mem_en` at cycle 1, ack[0] at cycle 3, `core_rdata[0]`=0xBEEF, `busy` high cycles 1-3.
- **All NUM_C=4 cores request at once after reset, holding until ack.**
  - Required: grants in order 0,1,2,3, with acks at cycles 3, 7, 11, 15.
- **Rotation:** after core 2 is served, cores 1 and 3 request together.
  - Required: core 3 is granted first, then core 1.
- **Store then load:** core 1 stores 0x1234 to 0x0005, then core 2 loads 0x0005.
  - Required: `core_rdata[2]`=0x1234; `core_rdata[1]` unchanged by the store.
- **Reset during WAIT:** core 0 load in progress, `rst_n` low for 2 cycles.
  - Required: immediate `mem_en`/`ack`=0; no ack[0]; after release, core 0 is again first priority.
- **Starvation check:** core 0 re-requests immediately after every ack while core 3 holds req continuously.
  - Required: acks alternate 0,3,0,3.

Source files
------------

// File: rtl/dm_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : dm_arbiter                                           |
// | Description : Round-robin arbiter and four-state sequencer sharing |
// |               one registered-read data RAM among NUM_C cores.      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module dm_arbiter #(
    parameter int NUM_C = 4,
    parameter int AW    = 16,
    parameter int DW    = 16,
    localparam int GW   = (NUM_C > 1) ? $clog2(NUM_C) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_C-1:0]    core_req,
    input  logic [NUM_C-1:0]    core_we,
    input  logic [NUM_C*AW-1:0] core_addr,
    input  logic [NUM_C*DW-1:0] core_wdata,
    output logic [NUM_C-1:0]    core_ack,
    output logic [NUM_C*DW-1:0] core_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic                busy,
    output logic [GW-1:0]       grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [GW-1:0]       r_grant_id;
    logic [GW-1:0]       r_last_grant;
    logic                r_we;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [NUM_C*DW-1:0] r_core_rdata;

    logic                w_any;
    logic [GW-1:0]       w_winner;

    assign w_any      = |core_req;
    assign grant_id   = r_grant_id;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign core_rdata = r_core_rdata;

    // Pick the requester closest to (last_grant + 1) in ascending, wrapping order.
    always_comb begin
        int v_best;
        int v_dist;
        v_best   = NUM_C;
        v_dist   = 0;
        w_winner = '0;
        for (int i = 0; i < NUM_C; i++) begin
            v_dist = (i + NUM_C - 1 - int'(r_last_grant)) % NUM_C;
            if (core_req[i] && (v_dist < v_best)) begin
                v_best   = v_dist;
                w_winner = GW'(i);
            end
        end
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        busy        = 1'b1;
        core_ack    = '0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_any) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en      = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                for (int i = 0; i < NUM_C; i++) begin
                    if (GW'(i) == r_grant_id) begin
                        core_ack[i] = 1'b1;
                    end
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's request in IDLE and capture load data at the WAIT->ACK edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_C - 1);
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_rdata <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any) begin
                r_grant_id   <= w_winner;
                r_last_grant <= w_winner;
                r_we         <= core_we[w_winner];
                r_addr       <= core_addr[w_winner*AW +: AW];
                r_wdata      <= core_wdata[w_winner*DW +: DW];
            end
            if ((r_state == ST_WAIT) && !r_we) begin
                for (int i = 0; i < NUM_C; i++) begin
                    if (GW'(i) == r_grant_id) begin
                        r_core_rdata[i*DW +: DW] <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_dm_arbiter                                        |
// | Description : Self-checking bench for dm_arbiter: directed cases   |
// |               plus randomized traffic against a transaction model. |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_dm_arbiter;

    localparam int NUM_C = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int GW    = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NUM_C-1:0]    core_req;
    logic [NUM_C-1:0]    core_we;
    logic [NUM_C*AW-1:0] core_addr;
    logic [NUM_C*DW-1:0] core_wdata;
    logic [NUM_C-1:0]    core_ack;
    logic [NUM_C*DW-1:0] core_rdata;
    logic                mem_en;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;
    logic                busy;
    logic [GW-1:0]       grant_id;

    dm_arbiter #(.NUM_C(NUM_C), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    // Registered-read RAM seen by the DUT.
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    // Reference model: one transaction at a time, phase = cycles since grant.
    int            m_phase;
    int            m_last;
    int            m_cur;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_load;
    logic [DW-1:0] m_mem [0:255];
    logic [DW-1:0] m_rd  [NUM_C];

    // Requester stimulus controls.
    bit            launch [NUM_C];
    logic          l_we   [NUM_C];
    logic [AW-1:0] l_addr [NUM_C];
    logic [DW-1:0] l_wdata[NUM_C];
    bit            rereq  [NUM_C];
    bit            rand_mode;

    int n_cmp;
    int n_bad;
    int cyc;
    int obs_id [$];
    int obs_cyc[$];
    logic s_busy;
    logic s_mem_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_last  = NUM_C - 1;
        m_cur   = 0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        for (int i = 0; i < NUM_C; i++) m_rd[i] = '0;
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_C-1:0] e_ack;
        e_ack = (m_phase == 3) ? (NUM_C'(1) << m_cur) : '0;
        chk({tag, "_busy"},   64'(busy),     64'(m_phase != 0));
        chk({tag, "_mem_en"}, 64'(mem_en),   64'(m_phase == 1));
        chk({tag, "_ack"},    64'(core_ack), 64'(e_ack));
        chk({tag, "_gid"},    64'(grant_id), 64'(m_cur));
        chk({tag, "_mwe"},    64'(mem_we),   64'(m_we));
        chk({tag, "_maddr"},  64'(mem_addr), 64'(m_addr));
        if (m_phase == 1) chk({tag, "_mwdata"}, 64'(mem_wdata), 64'(m_wdata));
        for (int i = 0; i < NUM_C; i++)
            chk({tag, "_rdata"}, 64'(core_rdata[i*DW +: DW]), 64'(m_rd[i]));
    endtask

    task automatic new_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req[i]             = 1'b1;
        core_we[i]              = we;
        core_addr[i*AW +: AW]   = a;
        core_wdata[i*DW +: DW]  = d;
    endtask

    task automatic model_advance();
        bit found;
        int c;
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 1; k <= NUM_C; k++) begin
                    c = (m_last + k) % NUM_C;
                    if (!found && core_req[c]) begin
                        found   = 1'b1;
                        m_cur   = c;
                        m_last  = c;
                        m_we    = core_we[c];
                        m_addr  = core_addr[c*AW +: AW];
                        m_wdata = core_wdata[c*DW +: DW];
                        m_phase = 1;
                    end
                end
            end
            1: begin
                if (m_we) m_mem[m_addr[7:0]] = m_wdata;
                else      m_load = m_mem[m_addr[7:0]];
                m_phase = 2;
            end
            2: begin
                if (!m_we) m_rd[m_cur] = m_load;
                m_phase = 3;
            end
            default: m_phase = 0;
        endcase
    endtask

    // One clock cycle: check this cycle's outputs, update requesters, advance model.
    task automatic step();
        @(negedge clk);
        check_outputs("cyc");
        s_busy   = busy;
        s_mem_en = mem_en;
        for (int i = 0; i < NUM_C; i++) begin
            if (core_ack[i]) begin
                obs_id.push_back(i);
                obs_cyc.push_back(cyc);
            end
        end
        for (int i = 0; i < NUM_C; i++) begin
            if (m_phase == 3 && m_cur == i) begin
                core_req[i] = 1'b0;
                if (rereq[i]) new_req(i, 1'b0, AW'(16'h0010), '0);
            end else if (launch[i]) begin
                new_req(i, l_we[i], l_addr[i], l_wdata[i]);
                launch[i] = 1'b0;
            end else if (rand_mode && !core_req[i] && $urandom_range(0, 2) == 0) begin
                new_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 17)), DW'($urandom));
            end
        end
        model_advance();
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        core_req = '0;
        model_reset();
        #1;
        check_outputs("rst");
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_ack", 64'(core_ack), 64'(0));
        end
        check_outputs("rst_hold");
        rst_n = 1'b1;
        cyc   = 0;
        obs_id.delete();
        obs_cyc.delete();
    endtask

    task automatic go(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        launch[i]  = 1'b1;
        l_we[i]    = we;
        l_addr[i]  = a;
        l_wdata[i] = d;
    endtask

    task automatic chk_obs(input string tag, input int k, input int id, input int c);
        chk({tag, "_id"}, 64'((k < obs_id.size()) ? obs_id[k] : 99), 64'(id));
        if (c >= 0) chk({tag, "_cyc"}, 64'((k < obs_cyc.size()) ? obs_cyc[k] : 999), 64'(c));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        rand_mode = 1'b0;
        rst_n     = 1'b0;
        core_req  = '0;
        core_we   = '0;
        core_addr = '0;
        core_wdata = '0;
        for (int i = 0; i < NUM_C; i++) begin
            launch[i] = 1'b0;
            rereq[i]  = 1'b0;
        end
        for (int i = 0; i < 256; i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        ram[16]   = 16'hBEEF;
        m_mem[16] = 16'hBEEF;
        #12;

        // Single load: mem_en at cycle 1, busy cycles 1-3, ack at cycle 3.
        apply_reset();
        go(0, 1'b0, 16'h0010, 16'h0000);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("ld_busy",  64'(s_busy),   64'(c >= 1 && c <= 3));
            chk("ld_mem_en", 64'(s_mem_en), 64'(c == 1));
        end
        chk_obs("ld_ack", 0, 0, 3);
        chk("ld_rdata0", 64'(core_rdata[15:0]), 64'(16'hBEEF));

        // All cores at once: order 0,1,2,3 with acks at 3,7,11,15.
        apply_reset();
        for (int i = 0; i < NUM_C; i++) go(i, 1'b0, AW'(i), '0);
        repeat (17) step();
        for (int k = 0; k < NUM_C; k++) chk_obs("all", k, k, 3 + 4 * k);

        // Rotation: after core 2, cores 1 and 3 together -> 3 then 1.
        apply_reset();
        go(2, 1'b0, 16'h0001, '0);
        repeat (4) step();
        go(1, 1'b0, 16'h0002, '0);
        go(3, 1'b0, 16'h0003, '0);
        repeat (8) step();
        chk_obs("rot0", 0, 2, -1);
        chk_obs("rot1", 1, 3, -1);
        chk_obs("rot2", 2, 1, -1);

        // Store then load; the store leaves the storing core's rdata alone.
        go(1, 1'b0, 16'h0010, '0);
        repeat (4) step();
        go(1, 1'b1, 16'h0005, 16'h1234);
        repeat (4) step();
        go(2, 1'b0, 16'h0005, '0);
        repeat (4) step();
        chk("st_ld_rdata2", 64'(core_rdata[2*DW +: DW]), 64'(16'h1234));
        chk("st_rdata1",    64'(core_rdata[1*DW +: DW]), 64'(16'hBEEF));

        // Reset during WAIT: no ack, then core 0 again has first priority.
        apply_reset();
        go(0, 1'b0, 16'h0010, '0);
        repeat (3) step();
        chk("rstw_noack", 64'(obs_id.size()), 64'(0));
        apply_reset();
        chk("rstw_busy",   64'(busy),     64'(0));
        chk("rstw_mem_en", 64'(mem_en),   64'(0));
        go(1, 1'b0, 16'h0001, '0);
        go(0, 1'b0, 16'h0002, '0);
        repeat (8) step();
        chk_obs("rstw0", 0, 0, 3);
        chk_obs("rstw1", 1, 1, 7);

        // Starvation: cores 0 and 3 re-request after every ack -> 0,3,0,3.
        apply_reset();
        rereq[0] = 1'b1;
        rereq[3] = 1'b1;
        go(0, 1'b0, 16'h0010, '0);
        go(3, 1'b0, 16'h0010, '0);
        repeat (16) step();
        for (int k = 0; k < 4; k++) chk_obs("starve", k, (k % 2 == 0) ? 0 : 3, 3 + 4 * k);
        rereq[0] = 1'b0;
        rereq[3] = 1'b0;

        // Randomized traffic against the model.
        apply_reset();
        rand_mode = 1'b1;
        repeat (800) step();
        rand_mode = 1'b0;
        repeat (12) step();
        chk("rand_some_acks", 64'(obs_id.size() > 50), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
